// File: rtl/pool_stream_if.sv
// pool_stream_if
//   Stream bundle between a feature-map producer/consumer and pool_stream_engine.
//   Signals:
//     mode      pooling mode (0 = max, 1 = average), sampled by the engine at frame start
//     in_valid  / in_ready / in_data    input element handshake (signed data)
//     out_valid / out_ready / out_data  pooled element handshake (signed data)
//     all_done  one-cycle end-of-frame pulse from the engine
//   Modports: master = environment side, slave = engine side.
interface pool_stream_if #(
    parameter int DATA_W = 8
);
    logic              mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              all_done;

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, all_done
    );

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, all_done
    );
endinterface

// File: rtl/pool_stream_engine.sv
// pool_stream_engine
//   Streaming 2-D max/average pooling over a row-major, channel-interleaved
//   feature map. Non-overlapping POOLxPOOL windows; one pooled element is
//   produced per completed window, in (out_row, out_col, channel) order.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   pool_stream_if.slave: mode, in_valid/in_ready/in_data,
//           out_valid/out_ready/out_data, all_done
module pool_stream_engine #(
    parameter int DATA_W     = 8,
    parameter int MAP_WIDTH  = 28,
    parameter int MAP_HEIGHT = 28,
    parameter int CHANNELS   = 1,
    parameter int POOL       = 2
) (
    input logic         clk,
    input logic         rst,
    pool_stream_if.slave bus
);
    localparam int LOG2P     = $clog2(POOL);
    localparam int SH        = 2 * LOG2P;
    localparam int SUM_W     = DATA_W + SH;
    localparam int OUT_W     = MAP_WIDTH / POOL;
    localparam int OUT_H     = MAP_HEIGHT / POOL;
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int COL_W     = $clog2(MAP_WIDTH);
    localparam int ROW_W     = $clog2(MAP_HEIGHT);
    localparam int ENTRIES   = CHANNELS * OUT_W;
    localparam int IDX_W     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int OUT_TOTAL = OUT_W * OUT_H * CHANNELS;
    localparam int OCNT_W    = (OUT_TOTAL > 1) ? $clog2(OUT_TOTAL) : 1;

    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(MAP_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(MAP_HEIGHT - 1);
    // One extra bit so the limit is representable when the map divides evenly
    localparam logic [COL_W:0]    COL_LIM  = (COL_W + 1)'(OUT_W * POOL);
    localparam logic [ROW_W:0]    ROW_LIM  = (ROW_W + 1)'(OUT_H * POOL);
    localparam logic [OCNT_W-1:0] OUT_LAST = OCNT_W'(OUT_TOTAL - 1);

    // Position counters of the next element to be accepted
    logic [CH_W-1:0]   ch_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic              mode_q;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              all_done_q;

    logic [OCNT_W-1:0] out_cnt_q;
    logic              in_end_seen_q;
    logic              out_end_seen_q;

    logic signed [SUM_W-1:0] acc [ENTRIES];

    logic                    fire;
    logic                    out_fire;
    logic                    frame_start;
    logic                    ch_last;
    logic                    col_last;
    logic                    row_last;
    logic                    in_win;
    logic                    win_first;
    logic                    win_last;
    logic [IDX_W-1:0]        idx;
    logic signed [SUM_W-1:0] x_ext;
    logic signed [SUM_W-1:0] acc_rd;
    logic signed [SUM_W-1:0] combined;
    logic signed [SUM_W-1:0] shifted;
    logic [DATA_W-1:0]       result;
    logic                    in_end;
    logic                    out_end;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.all_done  = all_done_q;

    assign fire        = bus.in_valid && bus.in_ready;
    assign out_fire    = out_valid_q && bus.out_ready;
    assign frame_start = (ch_q == '0) && (col_q == '0) && (row_q == '0);
    assign ch_last     = (ch_q == CH_LAST);
    assign col_last    = (col_q == COL_LAST);
    assign row_last    = (row_q == ROW_LAST);

    // Trailing rows/columns that do not fill a whole window are dropped
    assign in_win    = ({1'b0, col_q} < COL_LIM) && ({1'b0, row_q} < ROW_LIM);
    assign win_first = (row_q[LOG2P-1:0] == '0) && (col_q[LOG2P-1:0] == '0);
    assign win_last  = (row_q[LOG2P-1:0] == '1) && (col_q[LOG2P-1:0] == '1);

    // Bank entry for (output column, channel); channel is the fastest index
    assign idx = IDX_W'(32'(col_q >> LOG2P) * 32'(CHANNELS) + 32'(ch_q));

    assign x_ext  = {{SH{bus.in_data[DATA_W-1]}}, bus.in_data};
    assign acc_rd = acc[idx];

    always_comb begin
        combined = acc_rd;
        if (win_first) begin
            combined = x_ext;
        end else if (mode_q) begin
            combined = acc_rd + x_ext;
        end else if (x_ext > acc_rd) begin
            combined = x_ext;
        end
    end

    // Arithmetic shift floors toward -inf; the mean of DATA_W values fits DATA_W
    assign shifted = combined >>> SH;
    assign result  = mode_q ? DATA_W'(shifted) : DATA_W'(combined);

    assign in_end  = fire && ch_last && col_last && row_last;
    assign out_end = out_fire && (out_cnt_q == OUT_LAST);

    always_ff @(posedge clk) begin
        if (fire && in_win) begin
            acc[idx] <= combined;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q           <= '0;
            col_q          <= '0;
            row_q          <= '0;
            mode_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            all_done_q     <= 1'b0;
            out_cnt_q      <= '0;
            in_end_seen_q  <= 1'b0;
            out_end_seen_q <= 1'b0;
        end else begin
            all_done_q <= 1'b0;

            if (out_fire) begin
                out_valid_q <= 1'b0;
            end

            if (fire) begin
                if (frame_start) begin
                    mode_q <= bus.mode;
                end
                if (ch_last) begin
                    ch_q <= '0;
                    if (col_last) begin
                        col_q <= '0;
                        row_q <= row_last ? '0 : row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end else begin
                    ch_q <= ch_q + 1'b1;
                end
                // A new result may replace one being accepted in the same cycle
                if (in_win && win_last) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= result;
                end
            end

            if (out_fire) begin
                out_cnt_q <= (out_cnt_q == OUT_LAST) ? '0 : out_cnt_q + 1'b1;
            end

            // Frame completes on the later of last output accepted and last input accepted
            if ((out_end || out_end_seen_q) && (in_end || in_end_seen_q)) begin
                all_done_q     <= 1'b1;
                in_end_seen_q  <= 1'b0;
                out_end_seen_q <= 1'b0;
            end else begin
                if (out_end) begin
                    out_end_seen_q <= 1'b1;
                end
                if (in_end) begin
                    in_end_seen_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pool_stream_engine.sv
// tb_pool_stream_engine
//   Three engine instances (28x28/C1/P2, 8x8/C3/P4, 7x7/C1/P2) driven with
//   random frames; expected pooled values come from a window-level reference
//   model and are checked by a scoreboard monitor.
module tb_pool_stream_engine;
    localparam int NDUT = 3;
    localparam int CFG_W [NDUT] = '{28, 8, 7};
    localparam int CFG_H [NDUT] = '{28, 8, 7};
    localparam int CFG_C [NDUT] = '{1, 3, 1};
    localparam int CFG_P [NDUT] = '{2, 4, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       mode_s      [NDUT];
    logic       in_valid_s  [NDUT];
    logic [7:0] in_data_s   [NDUT];
    logic       out_ready_s [NDUT];
    logic       in_ready_w  [NDUT];
    logic       out_valid_w [NDUT];
    logic [7:0] out_data_w  [NDUT];
    logic       all_done_w  [NDUT];

    int exp_q [NDUT][$];
    int ready_duty [NDUT] = '{100, 100, 100};
    bit ignore_out [NDUT] = '{0, 0, 0};
    int done_cnt   [NDUT] = '{0, 0, 0};

    int vectors     = 0;
    int miscompares = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pool_stream_if #(.DATA_W(8)) bus ();
        assign bus.mode       = mode_s[g];
        assign bus.in_valid   = in_valid_s[g];
        assign bus.in_data    = in_data_s[g];
        assign bus.out_ready  = out_ready_s[g];
        assign in_ready_w[g]  = bus.in_ready;
        assign out_valid_w[g] = bus.out_valid;
        assign out_data_w[g]  = bus.out_data;
        assign all_done_w[g]  = bus.all_done;

        pool_stream_engine #(
            .DATA_W    (8),
            .MAP_WIDTH (CFG_W[g]),
            .MAP_HEIGHT(CFG_H[g]),
            .CHANNELS  (CFG_C[g]),
            .POOL      (CFG_P[g])
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    // Window-level reference: gather each window, take max or floored mean
    function automatic void ref_pool(input int k, input bit avg, input int px[$], output int res[$]);
        int w, h, c, p, n, best, sum, v;
        w = CFG_W[k]; h = CFG_H[k]; c = CFG_C[k]; p = CFG_P[k];
        n = p * p;
        res = {};
        for (int orow = 0; orow < h / p; orow++) begin
            for (int oc = 0; oc < w / p; oc++) begin
                for (int ch = 0; ch < c; ch++) begin
                    best = -100000;
                    sum  = 0;
                    for (int i = 0; i < p; i++) begin
                        for (int j = 0; j < p; j++) begin
                            v = px[((orow * p + i) * w + oc * p + j) * c + ch];
                            sum += v;
                            if (v > best) best = v;
                        end
                    end
                    if (avg) res.push_back((sum >= 0) ? sum / n : -((-sum + n - 1) / n));
                    else     res.push_back(best);
                end
            end
        end
    endfunction

    function automatic void rand_frame(input int k, input int lo, input int hi, output int q[$]);
        q = {};
        for (int i = 0; i < CFG_W[k] * CFG_H[k] * CFG_C[k]; i++)
            q.push_back(int'($urandom_range(hi - lo)) + lo);
    endfunction

    // Scoreboard monitor: randomises out_ready, checks handshake rule and pops expectations
    always @(negedge clk) begin
        int e;
        for (int k = 0; k < NDUT; k++)
            out_ready_s[k] = ($urandom_range(99) < ready_duty[k]);
        #1;
        if (!rst) begin
            for (int k = 0; k < NDUT; k++) begin
                vectors++;
                if (in_ready_w[k] !== (!out_valid_w[k] || out_ready_s[k])) begin
                    miscompares++;
                    $display("FAIL in_ready dut%0d: got %b want %b", k, in_ready_w[k],
                             !out_valid_w[k] || out_ready_s[k]);
                end
                if (out_valid_w[k] && out_ready_s[k] && !ignore_out[k]) begin
                    vectors++;
                    if (exp_q[k].size() == 0) begin
                        miscompares++;
                        $display("FAIL extra_output dut%0d: got %0d want none", k, $signed(out_data_w[k]));
                    end else begin
                        e = exp_q[k].pop_front();
                        if ($signed(out_data_w[k]) != e) begin
                            miscompares++;
                            $display("FAIL out_data dut%0d: got %0d want %0d", k, $signed(out_data_w[k]), e);
                        end
                    end
                end
                if (all_done_w[k] && !ignore_out[k]) begin
                    done_cnt[k]++;
                    vectors++;
                    if (exp_q[k].size() != 0) begin
                        miscompares++;
                        $display("FAIL early_all_done dut%0d: got %0d outputs pending want 0", k, exp_q[k].size());
                    end
                end
            end
        end
    end

    task automatic reset_dut(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) in_valid_s[k] = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            vectors++;
            if (out_valid_w[k] !== 1'b0 || out_data_w[k] !== 8'h00 || all_done_w[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got v=%b d=%h done=%b want 0 0 0", k,
                         out_valid_w[k], out_data_w[k], all_done_w[k]);
            end
        end
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // Sends the first n_send elements; a complete frame also gets its expectations and end checks
    task automatic run_frame(input int k, input bit avg, input int px[$], input int duty,
                             input int gap_pct, input int n_send);
        int res[$];
        int d0, waited;
        bit full;
        full = (n_send == px.size());
        ready_duty[k] = duty;
        d0 = done_cnt[k];
        if (full) begin
            ref_pool(k, avg, px, res);
            foreach (res[i]) exp_q[k].push_back(res[i]);
        end
        for (int i = 0; i < n_send; i++) begin
            @(negedge clk);
            while ($urandom_range(99) < gap_pct) begin
                in_valid_s[k] = 1'b0;
                @(negedge clk);
            end
            // Only the first element's mode matters; later flips must be ignored
            mode_s[k]     = (i == 0) ? avg : ~avg;
            in_valid_s[k] = 1'b1;
            in_data_s[k]  = 8'(px[i]);
            #2;
            waited = 0;
            while (!in_ready_w[k] && waited < 1000) begin
                @(negedge clk);
                #2;
                waited++;
            end
            if (!in_ready_w[k]) begin
                vectors++;
                miscompares++;
                $display("FAIL in_ready_timeout dut%0d: got 0 after %0d cycles want 1", k, waited);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid_s[k] = 1'b0;
        if (full) begin
            waited = 0;
            while (exp_q[k].size() != 0 && waited < 5000) begin
                @(negedge clk);
                waited++;
            end
            repeat (4) @(negedge clk);
            vectors++;
            if (exp_q[k].size() != 0) begin
                miscompares++;
                $display("FAIL missing_outputs dut%0d: got %0d undelivered want 0", k, exp_q[k].size());
                exp_q[k] = {};
            end
            vectors++;
            if (done_cnt[k] - d0 != 1) begin
                miscompares++;
                $display("FAIL all_done_count dut%0d: got %0d want 1", k, done_cnt[k] - d0);
            end
        end
    endtask

    initial begin
        int px[$];
        for (int k = 0; k < NDUT; k++) begin
            mode_s[k] = 1'b0;
            in_valid_s[k] = 1'b0;
            in_data_s[k] = 8'h00;
        end
        reset_dut(3);

        // 28x28 max, free-flowing output
        rand_frame(0, -127, 127, px);
        run_frame(0, 1'b0, px, 100, 0, px.size());

        // Average with floor on negative and positive windows
        rand_frame(0, -128, 127, px);
        px[0] = -1; px[1] = -2; px[28] = -3; px[29] = -4;
        px[2] = 1;  px[3] = 2;  px[30] = 3;  px[31] = 5;
        run_frame(0, 1'b1, px, 100, 20, px.size());

        // Heavy backpressure, both modes
        rand_frame(0, -128, 127, px);
        run_frame(0, 1'b1, px, 30, 30, px.size());
        rand_frame(0, -128, 127, px);
        run_frame(0, 1'b0, px, 30, 10, px.size());

        // Three channels, 4x4 windows
        rand_frame(1, -128, 127, px);
        run_frame(1, 1'b0, px, 100, 0, px.size());
        rand_frame(1, -128, 127, px);
        run_frame(1, 1'b1, px, 30, 20, px.size());

        // Odd map: discarded last row/column carry 127 and must not leak
        px = {};
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
                px.push_back((r == 6 || c == 6) ? 127 : -128);
        run_frame(2, 1'b0, px, 100, 0, px.size());
        rand_frame(2, -128, 127, px);
        run_frame(2, 1'b1, px, 50, 20, px.size());

        // Abort after 100 elements, then a clean frame
        ignore_out[0] = 1'b1;
        rand_frame(0, -128, 127, px);
        run_frame(0, 1'b1, px, 60, 10, 100);
        reset_dut(2);
        ignore_out[0] = 1'b0;
        rand_frame(0, -127, 127, px);
        run_frame(0, 1'b0, px, 70, 10, px.size());

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
